// File: rtl/ahb_slave_regfile.sv
// rtl/ahb_slave_regfile.sv - AHB-Lite subordinate fronting a word register file
// Programmable wait states, byte/halfword lanes, two-cycle ERROR on illegal access.
module ahb_slave_regfile #(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             write_q, write_d;
    logic [31:0]      hrdata_q, hrdata_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];

    logic       accept;
    logic       legal;
    logic       misaligned;
    logic       take_new;
    logic [3:0] lanes;
    logic       unused_htrans0;

    assign unused_htrans0 = HTRANS[0];
    assign accept         = HSEL && HREADY && HTRANS[1];

    always_comb begin
        misaligned = ((HSIZE == 3'b001) && HADDR[0]) ||
                     ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
        legal      = (HADDR[31:2] < 30'(DEPTH)) && (HSIZE <= 3'b010) && !misaligned;
    end

    always_comb begin
        case (size_q)
            2'b00:   lanes = 4'b0001 << off_q;
            2'b01:   lanes = off_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        off_d     = off_q;
        size_d    = size_q;
        write_d   = write_q;
        hrdata_d  = hrdata_q;
        mem_d     = mem_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        take_new  = 1'b0;

        case (state_q)
            ST_IDLE: take_new = 1'b1;
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 3'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_DATA: begin
                if (write_q) begin
                    for (int b = 0; b < 4; b++) begin
                        if (lanes[b]) mem_d[idx_q][8*b +: 8] = HWDATA[8*b +: 8];
                    end
                end else begin
                    hrdata_d = mem_q[idx_q];
                end
                take_new = 1'b1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP    = 1'b1;
                take_new = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Only states that end a data phase (HREADYOUT=1) may start the next one.
        if (take_new) begin
            state_d = ST_IDLE;
            if (accept) begin
                idx_d   = HADDR[IDX_W+1:2];
                off_d   = HADDR[1:0];
                size_d  = HSIZE[1:0];
                write_d = HWRITE;
                if (!legal) begin
                    state_d = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = ST_DATA;
                end
            end
        end
    end

    // Read data comes straight from the array during the read data phase, then is held.
    assign HRDATA = ((state_q == ST_DATA) && !write_q) ? mem_q[idx_q] : hrdata_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            off_q    <= 2'b00;
            size_q   <= 2'b00;
            write_q  <= 1'b0;
            hrdata_q <= 32'h0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_ahb_slave_regfile.sv
// tb/tb_ahb_slave_regfile.sv - directed bench for ahb_slave_regfile
// Two instances: WAIT_STATES=1 for the vector table and reset, WAIT_STATES=0 for pipelining.
module tb_ahb_slave_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        which;

    logic [31:0] hrdata0, hrdata1, hrdata_m;
    logic        ro0, ro1, rp0, rp1, ro_m, rp_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hrdata_m = which ? hrdata1 : hrdata0;
    assign ro_m     = which ? ro1 : ro0;
    assign rp_m     = which ? rp1 : rp0;

    ahb_slave_regfile #(.DEPTH(16), .WAIT_STATES(1)) u_ws1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && !which), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(ro0), .HRDATA(hrdata0), .HREADYOUT(ro0), .HRESP(rp0)
    );

    ahb_slave_regfile #(.DEPTH(16), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && which), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(ro1), .HRDATA(hrdata1), .HREADYOUT(ro1), .HRESP(rp1)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] wd;
        int          cyc;
        logic        resp;
        logic [31:0] rd;
    } vec_t;

    vec_t v [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, output int cyc, output logic first_ro,
                        output logic resp, output logic [31:0] rd);
        @(negedge clk);
        hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = s;
        cyc = 0; first_ro = 1'b1; resp = 1'b0; rd = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                hsel = 1'b0; htrans = 2'b00; hwdata = wd;
                first_ro = ro_m;
            end
            cyc++;
            resp = rp_m;
            if (ro_m) begin
                rd = hrdata_m;
                break;
            end
        end
    endtask

    initial begin
        int          cyc;
        logic        fro, rsp;
        logic [31:0] rd;

        v[0]  = '{1'b1, 32'h08, 3'b010, 32'hDEADBEEF, 2, 1'b0, 32'h0};
        v[1]  = '{1'b0, 32'h08, 3'b010, 32'h0,        2, 1'b0, 32'hDEADBEEF};
        v[2]  = '{1'b1, 32'h04, 3'b010, 32'h11223344, 2, 1'b0, 32'h0};
        v[3]  = '{1'b1, 32'h06, 3'b000, 32'h00AA0000, 2, 1'b0, 32'h0};
        v[4]  = '{1'b0, 32'h04, 3'b010, 32'h0,        2, 1'b0, 32'h11AA3344};
        v[5]  = '{1'b0, 32'h40, 3'b010, 32'h0,        2, 1'b1, 32'h0};
        v[6]  = '{1'b1, 32'h40, 3'b010, 32'h12345678, 2, 1'b1, 32'h0};
        v[7]  = '{1'b1, 32'h02, 3'b010, 32'h55555555, 2, 1'b1, 32'h0};
        v[8]  = '{1'b0, 32'h00, 3'b010, 32'h0,        2, 1'b0, 32'h0};
        v[9]  = '{1'b1, 32'h0E, 3'b001, 32'hBEEF0000, 2, 1'b0, 32'h0};
        v[10] = '{1'b1, 32'h0D, 3'b001, 32'h0000FFFF, 2, 1'b1, 32'h0};
        v[11] = '{1'b0, 32'h0C, 3'b010, 32'h0,        2, 1'b0, 32'hBEEF0000};
        v[12] = '{1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, 2, 1'b1, 32'h0};
        v[13] = '{1'b1, 32'h11, 3'b000, 32'h0000CD00, 2, 1'b0, 32'h0};
        v[14] = '{1'b0, 32'h3C, 3'b010, 32'h0,        2, 1'b0, 32'h0};
        v[15] = '{1'b0, 32'h10, 3'b010, 32'h0,        2, 1'b0, 32'h0000CD00};

        rst_n = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'b010; hwdata = 32'h0; which = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready0", 32'(ro0), 32'h1);
        check("rst_resp0", 32'(rp0), 32'h0);
        check("rst_rdata0", hrdata0, 32'h0);
        check("rst_ready1", 32'(ro1), 32'h1);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            xfer(v[k].w, v[k].a, v[k].s, v[k].wd, cyc, fro, rsp, rd);
            check($sformatf("v%0d_cycles", k), 32'(cyc), 32'(v[k].cyc));
            check($sformatf("v%0d_first_ready", k), 32'(fro), 32'h0);
            check($sformatf("v%0d_resp", k), 32'(rsp), 32'(v[k].resp));
            if (!v[k].w && !v[k].resp)
                check($sformatf("v%0d_rdata", k), rd, v[k].rd);
        end

        // Back-to-back write then read of the same word with zero wait states.
        which = 1'b1;
        @(negedge clk);
        hsel = 1'b1; haddr = 32'h0C; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(negedge clk);
        check("pipe_wr_ready", 32'(ro_m), 32'h1);
        check("pipe_wr_resp", 32'(rp_m), 32'h0);
        hwdata = 32'hCAFEF00D; hwrite = 1'b0;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        check("pipe_rd_ready", 32'(ro_m), 32'h1);
        check("pipe_rd_resp", 32'(rp_m), 32'h0);
        check("pipe_rd_data", hrdata_m, 32'hCAFEF00D);
        @(negedge clk);
        check("pipe_rd_hold", hrdata_m, 32'hCAFEF00D);

        // Reset asserted during the wait state of a write.
        which = 1'b0;
        @(negedge clk);
        hsel = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h77777777;
        check("rstmid_wait_ready", 32'(ro_m), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rstmid_ready", 32'(ro0), 32'h1);
        check("rstmid_resp", 32'(rp0), 32'h0);
        check("rstmid_rdata", hrdata0, 32'h0);
        check("rstmid_rdata1", hrdata1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h20, 3'b010, 32'h0, cyc, fro, rsp, rd);
        check("rstmid_rd_cycles", 32'(cyc), 32'd2);
        check("rstmid_rd_resp", 32'(rsp), 32'h0);
        check("rstmid_rd_data", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
